csr_bus_arbiter: RTL

//  Shares the CSR peripheral bus (read/modify/wdata/addr out, per-peripheral valid/rdata back) between
//  two requesters: req0 = core CSR stage, req1 = debug/host port. Round-robin grant, one access in flight,
//  3-state sequencer. Merges the peripheral response lanes; flags unmapped or multiply-decoded addresses.

---
 rtl/csr_bus_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter: shares the CSR peripheral bus between the core CSR stage
// (requester 0) and the debug/host port (requester 1). Round-robin grant,
// one access in flight, IDLE -> ISSUE -> WAIT sequencer, merged response lanes.
module csr_bus_arbiter #(
  parameter int          NPERIPH   = 8,
  parameter logic [11:0] IDLE_ADDR = 12'h000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rq0_valid,
  input  logic                   rq0_read,
  input  logic [2:0]             rq0_modify,
  input  logic [31:0]            rq0_wdata,
  input  logic [11:0]            rq0_addr,
  output logic                   rq0_ready,
  output logic                   rq0_resp,
  input  logic                   rq1_valid,
  input  logic                   rq1_read,
  input  logic [2:0]             rq1_modify,
  input  logic [31:0]            rq1_wdata,
  input  logic [11:0]            rq1_addr,
  output logic                   rq1_ready,
  output logic                   rq1_resp,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   csr_read,
  output logic [2:0]             csr_modify,
  output logic [31:0]            csr_wdata,
  output logic [11:0]            csr_addr,
  input  logic [NPERIPH-1:0]     periph_valid,
  input  logic [32*NPERIPH-1:0]  periph_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;      // grantee of the most recent handshake (1 after reset)
  logic        r_gnt;       // grantee of the access in flight
  logic        r_csr_read;
  logic [2:0]  r_csr_modify;
  logic [31:0] r_csr_wdata;
  logic [11:0] r_csr_addr;
  logic        r_resp0;
  logic        r_resp1;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_hs0;
  logic        w_hs1;
  logic [31:0] w_lane_or;
  logic        w_lane_err;

  // Error unless exactly one lane answered (zero lanes = unmapped, several = multiply decoded).
  function automatic logic lane_err(input logic [NPERIPH-1:0] v);
    return !((v != '0) && ((v & (v - NPERIPH'(1))) == '0));
  endfunction

  // Round-robin grant, only offered while the bus is idle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (rq0_valid && rq1_valid) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = rq0_valid;
        w_gnt1 = rq1_valid;
      end
    end
  end

  assign rq0_ready = w_gnt0;
  assign rq1_ready = w_gnt1;
  assign w_hs0     = rq0_valid & w_gnt0;
  assign w_hs1     = rq1_valid & w_gnt1;

  // Merge response lanes: invalid lanes drive zero, so a plain OR suffices.
  always_comb begin
    w_lane_or = '0;
    for (int i = 0; i < NPERIPH; i++) begin
      w_lane_or = w_lane_or | periph_rdata[32*i +: 32];
    end
    w_lane_err = lane_err(periph_valid);
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sequencer next state: each access takes exactly three cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs0 || w_hs1) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus drive, grant bookkeeping and response capture; reset drops any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last       <= 1'b1;
      r_gnt        <= 1'b0;
      r_csr_read   <= 1'b0;
      r_csr_modify <= 3'd0;
      r_csr_wdata  <= 32'd0;
      r_csr_addr   <= IDLE_ADDR;
      r_resp0      <= 1'b0;
      r_resp1      <= 1'b0;
      r_rsp_rdata  <= 32'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_resp0 <= 1'b0;
      r_resp1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs0 || w_hs1) begin
            r_csr_read   <= w_hs1 ? rq1_read   : rq0_read;
            r_csr_modify <= w_hs1 ? rq1_modify : rq0_modify;
            r_csr_wdata  <= w_hs1 ? rq1_wdata  : rq0_wdata;
            r_csr_addr   <= w_hs1 ? rq1_addr   : rq0_addr;
            r_gnt        <= w_hs1;
            r_last       <= w_hs1;
          end
        end
        S_ISSUE: begin
          // Modify strobe lasts one cycle so each access has exactly one side effect.
          r_csr_read   <= 1'b0;
          r_csr_modify <= 3'd0;
          r_csr_addr   <= IDLE_ADDR;
        end
        S_WAIT: begin
          r_rsp_rdata <= w_lane_or;
          r_rsp_err   <= w_lane_err;
          r_resp0     <= !r_gnt;
          r_resp1     <= r_gnt;
        end
        default: ;
      endcase
    end
  end

  assign csr_read   = r_csr_read;
  assign csr_modify = r_csr_modify;
  assign csr_wdata  = r_csr_wdata;
  assign csr_addr   = r_csr_addr;
  assign rq0_resp   = r_resp0;
  assign rq1_resp   = r_resp1;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;

endmodule
